// File: rtl/mem_cache_dm_pkg.sv
// Shared constants and types for the direct-mapped write-through cache slice.
package mem_cache_dm_pkg;

  localparam int data_width          = 32;
  localparam int addr_width          = 16;
  localparam int mem_simulated_delay = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_RD,
    ST_ISSUE_WR,
    ST_WAIT_RD,
    ST_WAIT_WR,
    ST_RESP
  } mem_cache_state_e;

  // Byte address with the in-word offset cleared.
  function automatic logic [addr_width-1:0] word_align(input logic [addr_width-1:0] a);
    return a & {{(addr_width-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/mem_cache_dm_if.sv
// Request/busy/ack bus shared by the core side and the mem_delayed side.
interface mem_cache_dm_if;
  import mem_cache_dm_pkg::*;

  logic                  rd_req;
  logic                  wr_req;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] wr_data;
  logic [data_width-1:0] rd_data;
  logic                  busy;
  logic                  ack;

  modport master (output rd_req, wr_req, addr, wr_data, input rd_data, busy, ack);
  modport slave  (input rd_req, wr_req, addr, wr_data, output rd_data, busy, ack);

endinterface

// File: rtl/mem_cache_tag_ram.sv
// Per-line valid/tag/data storage: combinational lookup, synchronous fill, valid clear on rst.
module mem_cache_tag_ram
  import mem_cache_dm_pkg::*;
#(
  parameter int num_lines = 16,
  parameter int index_w   = $clog2(num_lines),
  parameter int tag_w     = addr_width - 2 - index_w
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [index_w-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [tag_w-1:0]      rd_tag,
  output logic [data_width-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [index_w-1:0]    wr_index,
  input  logic [tag_w-1:0]      wr_tag,
  input  logic [data_width-1:0] wr_data
);

  logic [num_lines-1:0]  valid;
  logic [tag_w-1:0]      tags  [num_lines];
  logic [data_width-1:0] words [num_lines];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are intentionally left out of reset; a clear valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/mem_cache_dm.sv
// Direct-mapped, write-through, one-word-per-line cache in front of mem_delayed.
// Optional hit/miss counters are built when MEM_CACHE_STATS_EN is defined.
module mem_cache_dm
  import mem_cache_dm_pkg::*;
#(
  parameter int num_lines = 16
) (
  input  logic           clk,
  input  logic           rst,
  mem_cache_dm_if.slave  core,
  mem_cache_dm_if.master mem
`ifdef MEM_CACHE_STATS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
`endif
);

  localparam int index_w = $clog2(num_lines);
  localparam int tag_w   = addr_width - 2 - index_w;

  mem_cache_state_e state, state_next;

  logic [index_w-1:0]    req_index, fill_index, ram_index;
  logic [tag_w-1:0]      req_tag, fill_tag, ram_tag;
  logic [data_width-1:0] ram_data;
  logic                  ram_we;

  logic                  lk_valid;
  logic [tag_w-1:0]      lk_tag;
  logic [data_width-1:0] lk_data;

  logic                  accept, is_write, rd_hit;
  logic [addr_width-1:0] mem_addr_q;
  logic [data_width-1:0] mem_wr_data_q, rd_data_q;

  assign req_index  = core.addr[index_w+1:2];
  assign req_tag    = core.addr[addr_width-1:index_w+2];
  assign fill_index = mem_addr_q[index_w+1:2];
  assign fill_tag   = mem_addr_q[addr_width-1:index_w+2];

  // RESP has busy low, so a back-to-back request is taken there as well as in IDLE.
  assign accept   = ((state == ST_IDLE) || (state == ST_RESP)) && (core.rd_req || core.wr_req);
  assign is_write = core.wr_req;
  assign rd_hit   = lk_valid && (lk_tag == req_tag);

  mem_cache_tag_ram #(.num_lines(num_lines)) u_tag_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (lk_valid),
    .rd_tag   (lk_tag),
    .rd_data  (lk_data),
    .wr_en    (ram_we),
    .wr_index (ram_index),
    .wr_tag   (ram_tag),
    .wr_data  (ram_data)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_next = state;
    ram_we     = 1'b0;
    ram_index  = req_index;
    ram_tag    = req_tag;
    ram_data   = core.wr_data;
    mem.rd_req = 1'b0;
    mem.wr_req = 1'b0;
    unique case (state)
      ST_IDLE, ST_RESP: begin
        state_next = ST_IDLE;
        if (accept) begin
          if (is_write) begin
            // Write-allocate: lines hold one word and memory is write-through, so overwriting is always safe.
            ram_we     = 1'b1;
            state_next = ST_ISSUE_WR;
          end else if (rd_hit) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_ISSUE_RD;
          end
        end
      end
      ST_ISSUE_RD: begin
        if (!mem.busy) begin
          mem.rd_req = 1'b1;
          state_next = ST_WAIT_RD;
        end
      end
      ST_ISSUE_WR: begin
        if (!mem.busy) begin
          mem.wr_req = 1'b1;
          state_next = ST_WAIT_WR;
        end
      end
      ST_WAIT_RD: begin
        if (mem.ack) begin
          ram_we     = 1'b1;
          ram_index  = fill_index;
          ram_tag    = fill_tag;
          ram_data   = mem.rd_data;
          state_next = ST_RESP;
        end
      end
      ST_WAIT_WR: begin
        if (mem.ack) begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mem_addr_q    <= word_align(core.addr);
        mem_wr_data_q <= core.wr_data;
      end
      if (accept && !is_write && rd_hit) begin
        rd_data_q <= lk_data;
      end else if ((state == ST_WAIT_RD) && mem.ack) begin
        rd_data_q <= mem.rd_data;
      end
    end
  end

  assign core.busy    = (state == ST_ISSUE_RD) || (state == ST_ISSUE_WR) ||
                        (state == ST_WAIT_RD)  || (state == ST_WAIT_WR);
  assign core.ack     = (state == ST_RESP);
  assign core.rd_data = rd_data_q;
  assign mem.addr     = mem_addr_q;
  assign mem.wr_data  = mem_wr_data_q;

`ifdef MEM_CACHE_STATS_EN
  // Read-only statistics; both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept && !is_write) begin
      if (rd_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_cache_dm.sv
// Self-checking bench for mem_cache_dm: directed plan plus random traffic against an address-level cache model.
module tb_mem_cache_dm;
  import mem_cache_dm_pkg::*;

  localparam int num_lines = 16;
  localparam int miss_lat  = mem_simulated_delay + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_cache_dm_if core_if();
  mem_cache_dm_if mem_if();

`ifdef MEM_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  mem_cache_dm #(.num_lines(num_lines)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
`ifdef MEM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents: device copy (responder) and architectural expectation (model).
  logic [data_width-1:0] backing [int unsigned];
  logic [data_width-1:0] exp_mem [int unsigned];

  function automatic logic [data_width-1:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [data_width-1:0] exp_read(input int unsigned w);
    return exp_mem.exists(w) ? exp_mem[w] : init_word(w);
  endfunction

  // mem_delayed stand-in: request seen in cycle R, mem_ack in cycle R+delay.
  int                    rd_pulses = 0;
  int                    wr_pulses = 0;
  logic [addr_width-1:0] last_addr = '0;
  logic [data_width-1:0] last_wdata = '0;

  initial begin : mem_responder
    int          left;
    bit          pend_rd;
    int unsigned pend_word;
    left = 0; pend_rd = 1'b0; pend_word = 0;
    mem_if.busy = 1'b0; mem_if.ack = 1'b0; mem_if.rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        left = 0;
      end else begin
        if (mem_if.rd_req) rd_pulses++;
        if (mem_if.wr_req) wr_pulses++;
        if (left == 0 && (mem_if.rd_req || mem_if.wr_req)) begin
          left       = mem_simulated_delay;
          pend_rd    = mem_if.rd_req;
          pend_word  = 32'(mem_if.addr) >> 2;
          last_addr  = mem_if.addr;
          last_wdata = mem_if.wr_data;
          if (mem_if.wr_req) backing[pend_word] = mem_if.wr_data;
        end
      end
      @(posedge clk); #2;
      mem_if.ack = 1'b0;
      if (left > 0) begin
        left--;
        mem_if.busy = (left != 0);
        if (left == 0) begin
          mem_if.ack = 1'b1;
          if (pend_rd) mem_if.rd_data = backing.exists(pend_word) ? backing[pend_word] : init_word(pend_word);
        end
      end else begin
        mem_if.busy = 1'b0;
      end
    end
  end

  // Reference cache: which word each line holds, derived from address arithmetic only.
  bit                    m_valid [num_lines];
  int unsigned           m_tag   [num_lines];
  int                    exp_hits, exp_misses;
  logic [data_width-1:0] exp_rd_data;

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    exp_hits    = 0;
    exp_misses  = 0;
    exp_rd_data = '0;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [addr_width-1:0] a,
                        input logic [data_width-1:0] d, output int lat,
                        output logic [data_width-1:0] rdata, output bit saw_busy,
                        output bit ack_busy, output bit ack_after,
                        output logic [data_width-1:0] rdata_after);
    bit got;
    @(posedge clk); #1;
    core_if.rd_req = rd; core_if.wr_req = wr; core_if.addr = a; core_if.wr_data = d;
    @(posedge clk); #1;
    core_if.rd_req = 1'b0; core_if.wr_req = 1'b0;
    core_if.addr = addr_width'($urandom); core_if.wr_data = $urandom;
    got = 1'b0; lat = -1; saw_busy = 1'b0; ack_busy = 1'b0; rdata = 'x;
    for (int k = 1; k <= 64 && !got; k++) begin
      @(negedge clk);
      if (core_if.ack) begin
        got = 1'b1; lat = k; rdata = core_if.rd_data; ack_busy = core_if.busy;
      end else if (core_if.busy) begin
        saw_busy = 1'b1;
      end
    end
    @(negedge clk);
    ack_after   = core_if.ack;
    rdata_after = core_if.rd_data;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [addr_width-1:0] a,
                    input logic [data_width-1:0] d, input string tag);
    int unsigned           w, idx, tg;
    bit                    hit, saw_busy, ack_busy, ack_after;
    int                    lat, rp0, wp0;
    logic [data_width-1:0] rdata, rdata_after, exp_d;
    logic [addr_width-1:0] al;
    w   = 32'(a) >> 2;
    idx = w % num_lines;
    tg  = w / num_lines;
    hit = !wr && m_valid[idx] && (m_tag[idx] == tg);
    al  = a; al[1:0] = 2'b00;
    rp0 = rd_pulses; wp0 = wr_pulses;
    do_req(rd, wr, a, d, lat, rdata, saw_busy, ack_busy, ack_after, rdata_after);
    check({tag, "/latency"}, lat, hit ? 1 : miss_lat);
    check({tag, "/mem_rd_req_pulses"}, rd_pulses - rp0, (!wr && !hit) ? 1 : 0);
    check({tag, "/mem_wr_req_pulses"}, wr_pulses - wp0, wr ? 1 : 0);
    check({tag, "/busy_before_ack"}, saw_busy, !hit);
    check({tag, "/busy_in_ack"}, ack_busy, 0);
    check({tag, "/ack_one_cycle"}, ack_after, 0);
    if (!hit) check({tag, "/mem_addr"}, last_addr, al);
    if (wr) begin
      check({tag, "/mem_wr_data"}, last_wdata, d);
      check({tag, "/rd_data_unchanged"}, rdata, exp_rd_data);
      exp_mem[w] = d;
    end else begin
      exp_d = exp_read(w);
      check({tag, "/rd_data"}, rdata, exp_d);
      check({tag, "/rd_data_held"}, rdata_after, exp_d);
      exp_rd_data = exp_d;
      if (hit) exp_hits++; else exp_misses++;
    end
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef MEM_CACHE_STATS_EN
    check({tag, "/hit_count"}, hit_count, exp_hits);
    check({tag, "/miss_count"}, miss_count, exp_misses);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin : stimulus
    logic [addr_width-1:0] ra;
    bit                    rrd, rwr;
    bit                    saw_ack, saw_busy;
    core_if.rd_req = 1'b0; core_if.wr_req = 1'b0; core_if.addr = '0; core_if.wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset/busy", core_if.busy, 0);
    check("reset/ack", core_if.ack, 0);
    check("reset/rd_data", core_if.rd_data, 0);
    check("reset/mem_rd_req", mem_if.rd_req, 0);
    check("reset/mem_wr_req", mem_if.wr_req, 0);
    check("reset/mem_addr", mem_if.addr, 0);
    check_stats("reset");

    op(1'b1, 1'b0, 16'h0010, 32'h0, "rd_miss_0x10");
    op(1'b0, 1'b1, 16'h0008, 32'hab, "wr_0x8_ab");
    op(1'b1, 1'b0, 16'h0008, 32'h0, "rd_hit_0x8");
    op(1'b0, 1'b1, 16'h000b, 32'hcd, "wr_0xb_cd");
    op(1'b1, 1'b0, 16'h0008, 32'h0, "rd_hit_0x8_lowbits");
    op(1'b0, 1'b1, 16'h0008, 32'h11, "wr_0x8_11");
    op(1'b0, 1'b1, 16'h0048, 32'h22, "wr_0x48_evict");
    op(1'b1, 1'b0, 16'h0008, 32'h0, "rd_evicted_0x8");
    op(1'b1, 1'b1, 16'h0014, 32'h33, "rdwr_0x14_is_write");
    op(1'b1, 1'b0, 16'h0014, 32'h0, "rd_hit_0x14");

    // 64 words over 16 lines gives frequent conflicts; low address bits are random noise.
    for (int i = 0; i < 80; i++) begin
      ra  = addr_width'($urandom_range(0, 255));
      rrd = ($urandom_range(0, 2) != 0);
      rwr = !rrd || ($urandom_range(0, 9) == 0);
      op(rrd, rwr, ra, $urandom, $sformatf("rand%0d", i));
    end
    check_stats("after_random");

    op(1'b1, 1'b0, 16'h0020, 32'h0, "pre_rst_fill_0x20");

    // Reset lands while the miss for 0x400 is waiting on memory.
    @(posedge clk); #1;
    core_if.rd_req = 1'b1; core_if.addr = 16'h0400;
    @(posedge clk); #1;
    core_if.rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    saw_ack = 1'b0; saw_busy = 1'b0;
    repeat (miss_lat + 4) begin
      @(negedge clk);
      if (core_if.ack)  saw_ack  = 1'b1;
      if (core_if.busy) saw_busy = 1'b1;
    end
    check("rst_mid/no_ack", saw_ack, 0);
    check("rst_mid/no_busy", saw_busy, 0);
    check("rst_mid/rd_data", core_if.rd_data, 0);
    check_stats("rst_mid");

    op(1'b1, 1'b0, 16'h0400, 32'h0, "post_rst_rd_0x400");
    op(1'b1, 1'b0, 16'h0020, 32'h0, "post_rst_rd_0x20");
    op(1'b1, 1'b0, 16'h0030, 32'h0, "post_rst_rd_0x30");
    op(1'b1, 1'b0, 16'h0400, 32'h0, "hit1_0x400");
    op(1'b1, 1'b0, 16'h0020, 32'h0, "hit2_0x20");
    op(1'b1, 1'b0, 16'h0030, 32'h0, "hit3_0x30");
    op(1'b1, 1'b0, 16'h0022, 32'h0, "hit4_0x22");
    op(1'b1, 1'b0, 16'h0401, 32'h0, "hit5_0x401");
    check_stats("three_miss_five_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
